// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle, hazard handshake and counters of the ID/EX stage.
// master: decode/execute side (drives id_*, ex_flush). slave: the ID/EX stage.
interface id_ex_stage_if #(
    parameter int PC_W   = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [6:0]        id_opcode;
    logic              id_alusrc, id_memtoreg, id_regwrite, id_memread;
    logic              id_memwrite, id_branch, id_jump, id_pcr;
    logic [1:0]        id_aluop;
    logic [PC_W-1:0]   id_pc;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [2:0]        id_funct3;
    logic [6:0]        id_funct7;
    logic              ex_flush;

    logic              ex_valid;
    logic              ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread;
    logic              ex_memwrite, ex_branch, ex_jump, ex_pcr;
    logic [1:0]        ex_aluop;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [2:0]        ex_funct3;
    logic [6:0]        ex_funct7;
    logic              pc_write, if_id_write;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output id_valid, id_opcode, id_alusrc, id_memtoreg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_jump, id_pcr, id_aluop, id_pc, id_rd1, id_rd2,
               id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7, ex_flush,
        input  ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
               ex_branch, ex_jump, ex_pcr, ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, pc_write, if_id_write,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_alusrc, id_memtoreg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_jump, id_pcr, id_aluop, id_pc, id_rd1, id_rd2,
               id_imm, id_rs1, id_rs2, id_rd, id_funct3, id_funct7, ex_flush,
        output ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
               ex_branch, ex_jump, ex_pcr, ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, pc_write, if_id_write,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// on stall or EX flush, and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int PC_W   = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic              valid;
        logic              alusrc, memtoreg, regwrite, memread;
        logic              memwrite, branch, jump, pcr;
        logic [1:0]        aluop;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] rd1, rd2, imm;
        logic [4:0]        rs1, rs2, rd;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
    } ex_bundle_t;

    ex_bundle_t       ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             rs1_used, rs2_used, hazard, stall, kill, keep_ctrl;

    // Source-register usage and load-use detection; depends only on EX flops and id_* inputs
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (bus.id_opcode)
            7'b0110111, 7'b0010111, 7'b1101111: rs1_used = 1'b0;
            default:                            rs1_used = 1'b1;
        endcase
        case (bus.id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: rs2_used = 1'b1;
            default:                            rs2_used = 1'b0;
        endcase
        hazard = ex_q.valid && ex_q.memread && (ex_q.rd != 5'd0) && bus.id_valid &&
                 ((rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                  (rs2_used && (bus.id_rs2 == ex_q.rd)));
        // A flush takes priority: the redirect owns the PC, so never hold it then.
        stall     = hazard && !bus.ex_flush;
        kill      = bus.ex_flush || hazard;
        keep_ctrl = bus.id_valid && !kill;
    end

    // Next EX bundle: copy decode, zeroing control whenever the slot becomes a bubble
    always_comb begin
        ex_d          = '0;
        ex_d.valid    = keep_ctrl;
        ex_d.alusrc   = keep_ctrl && bus.id_alusrc;
        ex_d.memtoreg = keep_ctrl && bus.id_memtoreg;
        ex_d.regwrite = keep_ctrl && bus.id_regwrite;
        ex_d.memread  = keep_ctrl && bus.id_memread;
        ex_d.memwrite = keep_ctrl && bus.id_memwrite;
        ex_d.branch   = keep_ctrl && bus.id_branch;
        ex_d.jump     = keep_ctrl && bus.id_jump;
        ex_d.pcr      = keep_ctrl && bus.id_pcr;
        ex_d.aluop    = keep_ctrl ? bus.id_aluop : 2'b00;
        ex_d.pc       = bus.id_pc;
        ex_d.rd1      = bus.id_rd1;
        ex_d.rd2      = bus.id_rd2;
        ex_d.imm      = bus.id_imm;
        ex_d.rs1      = bus.id_rs1;
        ex_d.rs2      = bus.id_rs2;
        ex_d.rd       = bus.id_rd;
        ex_d.funct3   = bus.id_funct3;
        ex_d.funct7   = bus.id_funct7;
    end

    // Saturating event counters: hold at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.ex_flush) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end else if (hazard) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Pipeline and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Hold requests are released while reset is asserted, even mid-stall.
    assign bus.pc_write    = reset || !stall;
    assign bus.if_id_write = reset || !stall;

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_alusrc   = ex_q.alusrc;
    assign bus.ex_memtoreg = ex_q.memtoreg;
    assign bus.ex_regwrite = ex_q.regwrite;
    assign bus.ex_memread  = ex_q.memread;
    assign bus.ex_memwrite = ex_q.memwrite;
    assign bus.ex_branch   = ex_q.branch;
    assign bus.ex_jump     = ex_q.jump;
    assign bus.ex_pcr      = ex_q.pcr;
    assign bus.ex_aluop    = ex_q.aluop;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_rd1      = ex_q.rd1;
    assign bus.ex_rd2      = ex_q.rd2;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_funct3   = ex_q.funct3;
    assign bus.ex_funct7   = ex_q.funct7;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (counters narrowed to 4 bits).
module tb_id_ex_stage;
    localparam int PC_W   = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int SAT    = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_if #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.PC_W(PC_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model of what EX should hold after each edge.
    bit              m_valid;
    bit [7:0]        m_ctrl;   // {alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,pcr}
    bit [1:0]        m_aluop;
    bit [PC_W-1:0]   m_pc;
    bit [DATA_W-1:0] m_rd1, m_rd2, m_imm;
    bit [4:0]        m_rs1, m_rs2, m_rd;
    bit [2:0]        m_f3;
    bit [6:0]        m_f7;
    int              m_stall, m_flush;

    function automatic bit model_hazard();
        bit reads1, reads2;
        reads1 = !(bus.id_opcode inside {OP_LUI, OP_AUI, OP_JAL});
        reads2 = bus.id_opcode inside {OP_R, OP_ST, OP_BR};
        return m_valid && m_ctrl[4] && (m_rd != 0) && bus.id_valid &&
               ((reads1 && bus.id_rs1 == m_rd) || (reads2 && bus.id_rs2 == m_rd));
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_valid = 0; m_ctrl = 0; m_aluop = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_f3 = 0; m_f7 = 0; m_stall = 0; m_flush = 0;
        end else if (bus.ex_flush || model_hazard()) begin
            if (bus.ex_flush) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
            else              m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
            m_valid = 0; m_ctrl = 0; m_aluop = 0;
        end else begin
            m_valid = bus.id_valid;
            m_ctrl  = bus.id_valid ? {bus.id_alusrc, bus.id_memtoreg, bus.id_regwrite, bus.id_memread,
                                      bus.id_memwrite, bus.id_branch, bus.id_jump, bus.id_pcr} : 8'h00;
            m_aluop = bus.id_valid ? bus.id_aluop : 2'b00;
            m_pc = bus.id_pc; m_rd1 = bus.id_rd1; m_rd2 = bus.id_rd2; m_imm = bus.id_imm;
            m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_rd = bus.id_rd;
            m_f3 = bus.id_funct3; m_f7 = bus.id_funct7;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_valid = 0; bus.id_opcode = 0; bus.id_alusrc = 0; bus.id_memtoreg = 0;
        bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_branch = 0;
        bus.id_jump = 0; bus.id_pcr = 0; bus.id_aluop = 0; bus.id_pc = 0; bus.id_rd1 = 0;
        bus.id_rd2 = 0; bus.id_imm = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_funct3 = 0; bus.id_funct7 = 0; bus.ex_flush = 0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic mr, input logic rw);
        clear_id();
        bus.id_valid = 1; bus.id_opcode = op; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_memread = mr; bus.id_memtoreg = mr; bus.id_regwrite = rw;
        bus.id_alusrc = (op != OP_R); bus.id_aluop = (op == OP_R) ? 2'b10 : 2'b00;
        bus.id_pc = PC_W'($urandom); bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
        bus.id_imm = $urandom; bus.id_funct3 = 3'($urandom); bus.id_funct7 = 7'($urandom);
    endtask

    task automatic rand_id();
        logic [6:0] ops [9];
        ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUI, OP_JAL, OP_JALR};
        bus.id_valid = ($urandom_range(0, 9) != 0);
        bus.id_opcode = ops[$urandom_range(0, 8)];
        {bus.id_alusrc, bus.id_memtoreg, bus.id_regwrite, bus.id_memread,
         bus.id_memwrite, bus.id_branch, bus.id_jump, bus.id_pcr} = 8'($urandom);
        bus.id_aluop = 2'($urandom);
        bus.id_pc = PC_W'($urandom); bus.id_rd1 = $urandom; bus.id_rd2 = $urandom;
        bus.id_imm = $urandom;
        bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
        bus.id_rd = 5'($urandom_range(0, 3));
        bus.id_funct3 = 3'($urandom); bus.id_funct7 = 7'($urandom);
        bus.ex_flush = ($urandom_range(0, 9) == 0);
    endtask

    task automatic test_reset();
        reset = 1;
        rand_id();
        #1;
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++;
            $display("FAIL reset_hold: pc_write=%0b if_id_write=%0b expected 1/1", bus.pc_write, bus.if_id_write); end
        tick(); tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.ex_memread !== 1'b0 ||
                      bus.ex_aluop !== 2'b00 || bus.ex_jump !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl: valid=%0b regwrite=%0b memread=%0b aluop=%0b expected 0", bus.ex_valid,
                     bus.ex_regwrite, bus.ex_memread, bus.ex_aluop); end
        checks++; if (bus.ex_rd1 !== 32'h0 || bus.ex_pc !== 9'h0 || bus.ex_rd !== 5'h0 || bus.ex_imm !== 32'h0) begin errors++;
            $display("FAIL reset_data: rd1=%0h pc=%0h rd=%0h imm=%0h expected 0", bus.ex_rd1, bus.ex_pc, bus.ex_rd, bus.ex_imm); end
        checks++; if (bus.stall_cnt !== 4'h0 || bus.flush_cnt !== 4'h0) begin errors++;
            $display("FAIL reset_cnt: stall=%0d flush=%0d expected 0/0", bus.stall_cnt, bus.flush_cnt); end
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++;
            $display("FAIL reset_write: pc_write=%0b if_id_write=%0b expected 1/1", bus.pc_write, bus.if_id_write); end
        reset = 0;
    endtask

    task automatic test_pass_through();
        clear_id();
        bus.id_valid = 1; bus.id_opcode = OP_R; bus.id_regwrite = 1; bus.id_aluop = 2'b10;
        bus.id_rd1 = 32'h1234; bus.id_rd = 5; bus.id_rs1 = 1; bus.id_rs2 = 2;
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1 || bus.ex_aluop !== 2'b10) begin errors++;
            $display("FAIL pass_ctrl: valid=%0b regwrite=%0b aluop=%0b expected 1/1/10", bus.ex_valid,
                     bus.ex_regwrite, bus.ex_aluop); end
        checks++; if (bus.ex_rd1 !== 32'h1234 || bus.ex_rd !== 5'd5) begin errors++;
            $display("FAIL pass_data: rd1=%0h rd=%0d expected 1234/5", bus.ex_rd1, bus.ex_rd); end
    endtask

    task automatic test_load_use();
        set_instr(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        set_instr(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
        #1;
        checks++; if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0) begin errors++;
            $display("FAIL lu_hold: pc_write=%0b if_id_write=%0b expected 0/0", bus.pc_write, bus.if_id_write); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.ex_memread !== 1'b0) begin errors++;
            $display("FAIL lu_bubble: valid=%0b regwrite=%0b memread=%0b expected 0", bus.ex_valid,
                     bus.ex_regwrite, bus.ex_memread); end
        checks++; if (bus.stall_cnt !== 4'd1) begin errors++;
            $display("FAIL lu_stall_cnt: got %0d expected 1", bus.stall_cnt); end
        checks++; if (bus.pc_write !== 1'b1) begin errors++;
            $display("FAIL lu_selfclear: pc_write=%0b expected 1", bus.pc_write); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rs1 !== 5'd5 || bus.ex_rd !== 5'd6) begin errors++;
            $display("FAIL lu_resume: valid=%0b rs1=%0d rd=%0d expected 1/5/6", bus.ex_valid, bus.ex_rs1, bus.ex_rd); end
    endtask

    task automatic test_no_false_hazard();
        // {load rd, consumer opcode, consumer rs1, consumer rs2}
        logic [4:0] ld_rd [3];
        logic [6:0] c_op  [3];
        logic [4:0] c_rs1 [3];
        logic [4:0] c_rs2 [3];
        ld_rd = '{5'd5, 5'd0, 5'd5};
        c_op  = '{OP_LUI, OP_R, OP_I};
        c_rs1 = '{5'd5, 5'd0, 5'd1};
        c_rs2 = '{5'd5, 5'd0, 5'd5};
        for (int i = 0; i < 3; i++) begin
            set_instr(OP_LD, 5'd2, 5'd0, ld_rd[i], 1'b1, 1'b1);
            tick();
            set_instr(c_op[i], c_rs1[i], c_rs2[i], 5'd1, 1'b0, 1'b1);
            #1;
            checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++;
                $display("FAIL nofalse_%0d: pc_write=%0b if_id_write=%0b expected 1/1", i, bus.pc_write, bus.if_id_write); end
            tick();
            checks++; if (bus.ex_valid !== 1'b1 || bus.ex_regwrite !== 1'b1) begin errors++;
                $display("FAIL nofalse_ex_%0d: valid=%0b regwrite=%0b expected 1/1", i, bus.ex_valid, bus.ex_regwrite); end
        end
    endtask

    task automatic test_flush_vs_hazard();
        set_instr(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        set_instr(OP_R, 5'd5, 5'd7, 5'd6, 1'b0, 1'b1);
        bus.ex_flush = 1;
        #1;
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++;
            $display("FAIL flush_write: pc_write=%0b if_id_write=%0b expected 1/1", bus.pc_write, bus.if_id_write); end
        tick();
        bus.ex_flush = 0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.ex_aluop !== 2'b00) begin errors++;
            $display("FAIL flush_bubble: valid=%0b regwrite=%0b aluop=%0b expected 0", bus.ex_valid,
                     bus.ex_regwrite, bus.ex_aluop); end
        checks++; if (bus.flush_cnt !== 4'd1 || bus.stall_cnt !== 4'd1) begin errors++;
            $display("FAIL flush_cnt: flush=%0d stall=%0d expected 1/1", bus.flush_cnt, bus.stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        set_instr(OP_LD, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1);
        tick();
        set_instr(OP_ST, 5'd3, 5'd9, 5'd0, 1'b0, 1'b0);
        #1;
        checks++; if (bus.pc_write !== 1'b0) begin errors++;
            $display("FAIL mid_stall_pre: pc_write=%0b expected 0", bus.pc_write); end
        reset = 1;
        #1;
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++;
            $display("FAIL mid_stall_rst: pc_write=%0b if_id_write=%0b expected 1/1", bus.pc_write, bus.if_id_write); end
        tick();
        reset = 0;
        checks++; if (bus.ex_valid !== 1'b0 || bus.ex_memread !== 1'b0 || bus.stall_cnt !== 4'd0 ||
                      bus.flush_cnt !== 4'd0) begin errors++;
            $display("FAIL mid_stall_clear: valid=%0b memread=%0b stall=%0d flush=%0d expected 0", bus.ex_valid,
                     bus.ex_memread, bus.stall_cnt, bus.flush_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] act_ctrl;
        bit         exp_w;
        for (int n = 0; n < 400; n++) begin
            rand_id();
            reset = ($urandom_range(0, 49) == 0);
            #1;
            exp_w = reset || !(model_hazard() && !bus.ex_flush);
            checks++; if (bus.pc_write !== exp_w || bus.if_id_write !== exp_w) begin errors++;
                $display("FAIL rand_write[%0d]: pc_write=%0b if_id_write=%0b expected %0b", n, bus.pc_write,
                         bus.if_id_write, exp_w); end
            tick();
            act_ctrl = {bus.ex_alusrc, bus.ex_memtoreg, bus.ex_regwrite, bus.ex_memread,
                        bus.ex_memwrite, bus.ex_branch, bus.ex_jump, bus.ex_pcr};
            checks++; if (bus.ex_valid !== m_valid || act_ctrl !== m_ctrl || bus.ex_aluop !== m_aluop) begin errors++;
                $display("FAIL rand_ctrl[%0d]: valid=%0b ctrl=%0h aluop=%0b expected %0b/%0h/%0b", n, bus.ex_valid,
                         act_ctrl, bus.ex_aluop, m_valid, m_ctrl, m_aluop); end
            checks++; if (bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush)) begin errors++;
                $display("FAIL rand_cnt[%0d]: stall=%0d flush=%0d expected %0d/%0d", n, bus.stall_cnt,
                         bus.flush_cnt, m_stall, m_flush); end
            if (m_valid) begin
                checks++;
                if (bus.ex_pc !== m_pc || bus.ex_rd1 !== m_rd1 || bus.ex_rd2 !== m_rd2 || bus.ex_imm !== m_imm ||
                    bus.ex_rs1 !== m_rs1 || bus.ex_rs2 !== m_rs2 || bus.ex_rd !== m_rd ||
                    bus.ex_funct3 !== m_f3 || bus.ex_funct7 !== m_f7) begin errors++;
                    $display("FAIL rand_data[%0d]: pc=%0h rd1=%0h rs1=%0d rd=%0d expected %0h/%0h/%0d/%0d", n,
                             bus.ex_pc, bus.ex_rd1, bus.ex_rs1, bus.ex_rd, m_pc, m_rd1, m_rs1, m_rd); end
            end
        end
        reset = 0;
    endtask

    task automatic test_saturation();
        clear_id();
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < SAT + 4; i++) begin
            set_instr(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
            tick();
            set_instr(OP_BR, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (bus.stall_cnt !== 4'hF) begin errors++;
            $display("FAIL sat_stall: got %0h expected F", bus.stall_cnt); end
        set_instr(OP_LD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
        tick();
        set_instr(OP_R, 5'd5, 5'd0, 5'd3, 1'b0, 1'b1);
        tick();
        checks++; if (bus.stall_cnt !== 4'hF || bus.flush_cnt !== 4'h0) begin errors++;
            $display("FAIL sat_hold: stall=%0h flush=%0h expected F/0", bus.stall_cnt, bus.flush_cnt); end
    endtask

    initial begin
        reset = 1;
        clear_id();
        @(posedge clk);
        #1;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_false_hazard();
        test_flush_vs_hazard();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RISC-V core. Captures the decode-stage control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, PCr), operands, immediate and register fields. Presents them to EX one cycle later.
- Contains load-use hazard detection. On a hazard it stalls PC and IF/ID and inserts a bubble into EX. A flush from EX on a taken branch or jump also inserts a bubble.
- Keeps a saturating stall/flush event counter for bring-up visibility.

Parameters:
- PC_W, 9, PC width.
- DATA_W, 32, register-operand and immediate width.
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_opcode  in  7  instr[6:0].
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch, id_jump, id_pcr  in  1 each  decoder control outputs.
- id_aluop  in  2  decoder ALUOp.
- id_pc  in  PC_W  PC of decode instruction.
- id_rd1, id_rd2  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct3  in  3; id_funct7  in  7.
- ex_flush  in  1  taken branch/jump resolved in EX; kill decode instruction.
- ex_* outputs  out  same widths as id_* (except opcode)  registered copies; plus ex_valid out 1.
- pc_write  out  1  0 = hold PC (combinational).
- if_id_write  out  1  0 = hold IF/ID (combinational).
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Behaviour:
- Reset, synchronous and active-high:
  - Clears all ex_* outputs, ex_valid, stall_cnt and flush_cnt to 0.
  - Forces pc_write=1 and if_id_write=1 during reset.
- Source-usage decode from id_opcode:
  - rs1_used is 0 for 0110111 (lui), 0010111 (auipc) and 1101111 (jal); 1 otherwise.
  - rs2_used is 1 for 0110011 (R), 0100011 (store) and 1100011 (branch); 0 otherwise.
- Load-use hazard, combinational, is asserted when all of the following hold:
  - ex_valid and ex_memread are set, and ex_rd != 0;
  - id_valid is set;
  - (rs1_used and id_rs1==ex_rd) or (rs2_used and id_rs2==ex_rd).
- Next-state priority per rising edge: reset > ex_flush > hazard > normal.
  - FLUSH (ex_flush=1):
    - Loads a bubble: ex_valid=0 and all ex control bits and ex_aluop = 0.
    - Data and field outputs may load the id_* values; they are don't-care when ex_valid=0.
    - pc_write=1 and if_id_write=1, because the fetch redirect owns the PC.
    - flush_cnt increments, saturating at all-ones.
  - STALL (hazard=1, ex_flush=0):
    - Loads a bubble as in FLUSH.
    - pc_write=0 and if_id_write=0, so the decode instruction is re-presented next cycle.
    - stall_cnt increments, saturating.
  - NORMAL: all ex_* load id_*, with ex_valid=id_valid. pc_write=1 and if_id_write=1.
- id_valid=0 while normal: control bits are zeroed in EX. A bubble never writes the register file or memory.
- Latency is exactly 1 cycle from id_* to ex_*. No combinational path from id_* to ex_*.
- Stall length: a load followed by a dependent instruction stalls exactly 1 cycle. After that cycle the load's ex_valid is replaced by the bubble, so the hazard self-clears.
- The hazard term depends only on registered EX state plus id_* inputs. It never depends on its own outputs, so there is no combinational loop.
- ex_rd==0 never triggers a hazard, for example a load to x0.
- Both counters hold at 2^CNT_W-1 when saturated and do not wrap.
- Reset asserted mid-stall: the next edge clears the stage, and pc_write returns to 1 in the same cycle as reset.

Test Plan:
- Reset: hold reset for 2 cycles with random id_* → all ex_* and counters = 0, pc_write=1, if_id_write=1.
- Pass-through: id_valid=1, opcode 0110011, regwrite=1, aluop=2'b10, rd1=32'h1234, rd=5 → next cycle ex_regwrite=1, ex_aluop=2'b10, ex_rd1=32'h1234, ex_rd=5, ex_valid=1.
- Load-use: cycle N EX has lw x5 (memread=1, rd=5); ID has add x6,x5,x7 → in cycle N pc_write=0 and if_id_write=0. Cycle N+1: ex_valid=0, ex_regwrite=0, stall_cnt=1. Cycle N+2: add reaches EX with ex_rs1=5.
- No false hazard:
  - lw x5 in EX, lui x5 in ID (rs1 unused) → no stall.
  - lw x0 in EX, add x1,x0,x0 in ID → no stall.
  - lw x5 in EX, addi with id_rs2 field=5 (rs2 unused) → no stall.
- Flush vs hazard: hazard condition and ex_flush=1 in the same cycle → bubble, pc_write=1, if_id_write=1, flush_cnt +1, stall_cnt unchanged.
- Saturation: preload by driving 2^CNT_W+3 stalls (CNT_W overridden to 4) → stall_cnt reads 4'hF and stays 4'hF.
